// File: rtl/seg7_scan_ctrl_if.sv
// Display-image load handshake between the counting logic (master)
// and the seg7 scan controller (slave).
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load_valid;
    logic                    load_ready;
    logic [4*NUM_DIGITS-1:0] load_data;
    logic [NUM_DIGITS-1:0]   load_dp;

    modport master (
        output load_valid,
        output load_data,
        output load_dp,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_dp,
        output load_ready
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed scan controller: double-buffered BCD image, blank gap plus
// dwell per digit, optional leading-zero suppression, one shared decoder.
module seg7_scan_ctrl #(
    parameter int          NUM_DIGITS   = 4,
    parameter logic [15:0] DWELL_CYCLES = 16'd10_000,
    parameter logic [15:0] BLANK_CYCLES = 16'd100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  lz_en,
    seg7_scan_ctrl_if.slave       load,
    output logic [3:0]            bcd,
    output logic                  blank,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  frame_done
);
    localparam int unsigned   ND   = NUM_DIGITS;
    localparam int            IW   = $clog2(NUM_DIGITS);
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    // With a zero-length gap every digit starts directly in SHOW.
    localparam state_t FIRST = (BLANK_CYCLES == 16'd0) ? SHOW : BLANK;

    state_t        state, nxt_state;
    logic [IW-1:0] idx, nxt_idx;
    logic [15:0]   cnt, nxt_cnt;
    logic          boundary;

    logic [4*ND-1:0] act_data, pend_data, act_data_nxt;
    logic [ND-1:0]   act_dp, pend_dp, act_dp_nxt;
    logic            pending, xfer;

    logic [ND-1:0]   sel_d;
    logic [3:0]      bcd_d;
    logic            blank_d, dp_d;
    logic [ND-1:0]   sup;
    logic            run;

    assign load.load_ready = !pending;

    // Transfer pending to active only at a frame boundary or while idle.
    assign xfer         = pending && (boundary || (state == IDLE));
    assign act_data_nxt = xfer ? pend_data : act_data;
    assign act_dp_nxt   = xfer ? pend_dp   : act_dp;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            digit_sel  <= '0;
            bcd        <= '0;
            blank      <= 1'b1;
            dp         <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= nxt_state;
            idx        <= nxt_idx;
            cnt        <= nxt_cnt;
            digit_sel  <= sel_d;
            bcd        <= bcd_d;
            blank      <= blank_d;
            dp         <= dp_d;
            frame_done <= boundary;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_cnt   = cnt + 16'd1;
        boundary  = 1'b0;
        if (!enable) begin
            nxt_state = IDLE;
            nxt_idx   = '0;
            nxt_cnt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    nxt_state = FIRST;
                    nxt_idx   = '0;
                    nxt_cnt   = '0;
                end
                BLANK: begin
                    if (cnt == BLANK_CYCLES - 16'd1) begin
                        nxt_state = SHOW;
                        nxt_cnt   = '0;
                    end
                end
                SHOW: begin
                    if (cnt == DWELL_CYCLES - 16'd1) begin
                        nxt_state = FIRST;
                        nxt_cnt   = '0;
                        if (idx == LAST) begin
                            nxt_idx  = '0;
                            boundary = 1'b1;
                        end else begin
                            nxt_idx = idx + 1'b1;
                        end
                    end
                end
                default: begin
                    nxt_state = IDLE;
                    nxt_idx   = '0;
                    nxt_cnt   = '0;
                end
            endcase
        end
    end

    // Outputs are computed from the next state and next image so that they
    // register on the same edge as the state itself.
    always_comb begin
        run = 1'b1;
        sup = '0;
        for (int unsigned k = 0; k < ND - 1; k++) begin
            run              = run & (act_data_nxt[4*(ND-1-k) +: 4] == 4'd0);
            sup[ND-1-k]      = run;
        end
        sel_d   = '0;
        bcd_d   = '0;
        blank_d = 1'b1;
        dp_d    = 1'b0;
        if (nxt_state == SHOW) begin
            sel_d[nxt_idx] = 1'b1;
            bcd_d          = act_data_nxt[{nxt_idx, 2'b00} +: 4];
            dp_d           = act_dp_nxt[nxt_idx];
            blank_d        = lz_en & sup[nxt_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_data  <= '0;
            act_dp    <= '0;
            pend_data <= '0;
            pend_dp   <= '0;
            pending   <= 1'b0;
        end else if (xfer) begin
            act_data <= pend_data;
            act_dp   <= pend_dp;
            pending  <= 1'b0;
        end else if (load.load_valid && !pending) begin
            pend_data <= load.load_data;
            pend_dp   <= load.load_dp;
            pending   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios plus random traffic, every
// cycle compared against a frame-position model of the scan.
module tb_seg7_scan_ctrl;
    localparam int ND = 4;
    localparam int DW = 4;
    localparam int BW = 2;
    localparam int SLOT = BW + DW;
    localparam int FL = ND * SLOT;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          lz_en = 1'b0;
    logic [3:0]    bcd;
    logic          blank, dp, frame_done;
    logic [ND-1:0] digit_sel;

    seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) lif ();

    seg7_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .DWELL_CYCLES(16'(DW)),
        .BLANK_CYCLES(16'(BW))
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .lz_en     (lz_en),
        .load      (lif),
        .bcd       (bcd),
        .blank     (blank),
        .dp        (dp),
        .digit_sel (digit_sel),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: position within the frame counted from the enable rise.
    bit          m_run, m_pf, m_fd, m_lz, bnd;
    int          m_t;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_adp, m_pdp;

    always @(posedge clk) begin
        if (reset) begin
            m_run = 0; m_t = 0; m_act = '0; m_adp = '0; m_pf = 0; m_fd = 0; m_lz = 0;
        end else begin
            bnd = m_run && enable && ((m_t % FL) == FL - 1);
            if (m_pf && (bnd || !m_run)) begin
                m_act = m_pend; m_adp = m_pdp; m_pf = 0;
            end else if (lif.load_valid && !m_pf) begin
                m_pend = lif.load_data; m_pdp = lif.load_dp; m_pf = 1;
            end
            m_fd = bnd;
            m_lz = lz_en;
            if (!enable) m_run = 0;
            else if (!m_run) begin m_run = 1; m_t = 0; end
            else m_t++;
        end
    end

    bit         chk_on = 0;
    int         p, d, w;
    logic [3:0] e_sel, e_bcd;
    logic       e_blank, e_dp;

    always @(negedge clk) begin
        if (chk_on) begin
            e_sel = '0; e_bcd = '0; e_blank = 1'b1; e_dp = 1'b0;
            if (m_run) begin
                p = m_t % FL;
                d = p / SLOT;
                w = p % SLOT;
                if (w >= BW) begin
                    e_sel   = 4'(1 << d);
                    e_bcd   = m_act[4*d +: 4];
                    e_dp    = m_adp[d];
                    e_blank = m_lz && (d > 0) && ((m_act >> (4*d)) == 16'd0);
                end
            end
            check("digit_sel",  32'(digit_sel),      32'(e_sel));
            check("bcd",        32'(bcd),            32'(e_bcd));
            check("blank",      32'(blank),          32'(e_blank));
            check("dp",         32'(dp),             32'(e_dp));
            check("frame_done", 32'(frame_done),     32'(m_fd));
            check("load_ready", 32'(lif.load_ready), 32'(!m_pf));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer an image and hold it until the controller takes it.
    task automatic load_img(input logic [15:0] img, input logic [3:0] pts);
        int k;
        lif.load_valid = 1'b1;
        lif.load_data  = img;
        lif.load_dp    = pts;
        for (k = 0; k < 200; k++) begin
            if (lif.load_ready) break;
            tick(1);
        end
        check("load_wait_bound", 32'(k < 200), 32'd1);
        tick(1);
        lif.load_valid = 1'b0;
    endtask

    task automatic wait_pos(input int pos);
        int k;
        for (k = 0; k < 200; k++) begin
            if (m_run && ((m_t % FL) == pos)) break;
            tick(1);
        end
        check("pos_wait_bound", 32'(k < 200), 32'd1);
    endtask

    bit acc;

    initial begin
        lif.load_valid = 1'b0;
        lif.load_data  = '0;
        lif.load_dp    = '0;
        tick(1);
        chk_on = 1;
        tick(1);
        reset = 1'b0;
        tick(1);

        // basic scan
        load_img(16'h1234, 4'b0000);
        tick(1);
        enable = 1'b1;
        tick(2 * FL);

        // leading-zero suppression
        lz_en = 1'b1;
        load_img(16'h0050, 4'b0100);
        tick(2 * FL);
        load_img(16'h0000, 4'b1010);
        tick(2 * FL);

        // handshake: second image held while the first is pending
        lz_en = 1'b0;
        wait_pos(7);
        load_img(16'h9876, 4'b0001);
        load_img(16'h1111, 4'b1111);
        tick(2 * FL);

        // accept exactly on the boundary cycle
        wait_pos(FL - 1);
        lif.load_valid = 1'b1;
        lif.load_data  = 16'h4321;
        lif.load_dp    = 4'b0010;
        tick(1);
        lif.load_valid = 1'b0;
        tick(2 * FL);

        // enable drop during SHOW(2), load while idle, re-enable
        wait_pos(2 * SLOT + BW + 1);
        enable = 1'b0;
        tick(2);
        lif.load_valid = 1'b1;
        lif.load_data  = 16'h5555;
        lif.load_dp    = 4'b0101;
        tick(1);
        lif.load_valid = 1'b0;
        tick(3);
        enable = 1'b1;
        tick(FL + 4);

        // reset mid-frame with an image pending
        wait_pos(9);
        load_img(16'h7777, 4'b1111);
        tick(2);
        reset  = 1'b1;
        enable = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(2);
        enable = 1'b1;
        tick(2 * FL);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 63) == 0) lz_en = ~lz_en;
            reset = ($urandom_range(0, 499) == 0);
            if (!lif.load_valid && ($urandom_range(0, 7) == 0)) begin
                lif.load_valid = 1'b1;
                lif.load_data  = 16'($urandom);
                lif.load_dp    = 4'($urandom);
            end
            acc = lif.load_valid && lif.load_ready;
            tick(1);
            if (acc) lif.load_valid = 1'b0;
        end
        reset = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
